// File: rtl/mips_pkg.sv
// mips_pkg: instruction kinds, opcode/funct constants and field widths shared by the loader and decoder
package mips_pkg;
  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;
  localparam int TGT_W = 26;
  localparam int FN_W  = 6;
  typedef enum logic [3:0] {
    K_ORI, K_ADDU, K_SUBU, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_ADDI, K_ADDIU, K_SLT, K_JAL, K_JR
  } op_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} ld_state_e;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [FN_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [FN_W-1:0] FN_SUBU  = 6'h23;
  localparam logic [FN_W-1:0] FN_SLT   = 6'h2A;
  localparam logic [FN_W-1:0] FN_JR    = 6'h08;
endpackage

// File: rtl/mips_imem_loader_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; flush takes priority over push/pop
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/mips_imem_loader.sv
// mips_imem_loader: encodes symbolic MIPS instructions, buffers them and writes them to IMEM,
// holding the core in reset until the image is complete
module mips_imem_loader
  import mips_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_kind,
  input  logic [4:0]        op_rs,
  input  logic [4:0]        op_rt,
  input  logic [4:0]        op_rd,
  input  logic [15:0]       op_imm,
  input  logic [25:0]       op_target,
  input  logic              op_last,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err
);
  ld_state_e state, state_nx;
  logic [31:0] enc;
  logic legal, accept, push, wr, ovf, go, full, empty;
  logic [ADDR_W-1:0] addr;
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (op_kind)
      K_ORI:   enc = {OP_ORI, op_rs, op_rt, op_imm};
      K_ADDU:  enc = {OP_RTYPE, op_rs, op_rt, op_rd, 5'd0, FN_ADDU};
      K_SUBU:  enc = {OP_RTYPE, op_rs, op_rt, op_rd, 5'd0, FN_SUBU};
      K_LW:    enc = {OP_LW, op_rs, op_rt, op_imm};
      K_SW:    enc = {OP_SW, op_rs, op_rt, op_imm};
      K_BEQ:   enc = {OP_BEQ, op_rs, op_rt, op_imm};
      K_LUI:   enc = {OP_LUI, 5'd0, op_rt, op_imm};
      K_J:     enc = {OP_J, op_target};
      K_ADDI:  enc = {OP_ADDI, op_rs, op_rt, op_imm};
      K_ADDIU: enc = {OP_ADDIU, op_rs, op_rt, op_imm};
      K_SLT:   enc = {OP_RTYPE, op_rs, op_rt, op_rd, 5'd0, FN_SLT};
      K_JAL:   enc = {OP_JAL, op_target};
      K_JR:    enc = {OP_RTYPE, op_rs, 15'd0, FN_JR};
      default: legal = 1'b0;
    endcase
  end
  assign op_ready = state == S_LOAD && !full && !err[1];
  assign accept   = op_valid && op_ready;
  assign push     = accept && legal;
  assign im_we    = !empty && state != S_IDLE;
  assign wr       = im_we && im_ready;
  assign ovf      = wr && addr == '1;
  assign go       = start && (state == S_IDLE || state == S_DONE);
  assign im_addr  = addr;
  assign done     = state == S_DONE;
  assign cpu_hold = !done;
  // an overflowing write drops everything still buffered
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(ovf), .push(push), .pop(wr),
    .din(enc), .dout(im_wdata), .full(full), .empty(empty)
  );
  always_comb
    state_nx = go ? S_LOAD
             : (state == S_LOAD && ((accept && op_last) || ovf)) ? S_DRAIN
             : (state == S_DRAIN && empty) ? S_DONE
             : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      addr  <= BASE_ADDR;
      err   <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        addr <= BASE_ADDR;
        err  <= '0;
      end else begin
        if (wr) addr <= addr + 1'b1;
        if (accept && !legal) err[0] <= 1'b1;
        if (ovf) err[1] <= 1'b1;
      end
    end
endmodule
